// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX memory arbiter: FSM state encoding and
// default widths and burst limit.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF    = 32;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 4;
  localparam int BURST_CNT_W   = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a shared single-port RAM, with
// burst limiting so neither port can starve the other.
module mem_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

  arb_state_t             state_reg;
  logic                   rr_ptr_reg;
  logic [BURST_CNT_W-1:0] burst_cnt_reg;
  logic                   burst_done;

  assign burst_done = (burst_cnt_reg == BURST_LAST);

  // rr_ptr remembers the last owner; on a tie from IDLE the other port wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= 1'b1;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0 && (!req1 || rr_ptr_reg)) begin
            state_reg     <= OWN0;
            rr_ptr_reg    <= 1'b0;
            burst_cnt_reg <= '0;
          end else if (req1) begin
            state_reg     <= OWN1;
            rr_ptr_reg    <= 1'b1;
            burst_cnt_reg <= '0;
          end
        end
        OWN0: begin
          if ((!req0 || burst_done) && req1) begin
            state_reg     <= OWN1;
            rr_ptr_reg    <= 1'b1;
            burst_cnt_reg <= '0;
          end else if (!req0) begin
            state_reg <= IDLE;
          end else if (!burst_done) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
          end
        end
        OWN1: begin
          if ((!req1 || burst_done) && req0) begin
            state_reg     <= OWN0;
            rr_ptr_reg    <= 1'b0;
            burst_cnt_reg <= '0;
          end else if (!req1) begin
            state_reg <= IDLE;
          end else if (!burst_done) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Grants are gated by reset so the RAM sees no write once reset is raised.
  assign gnt0 = ~reset & (state_reg == OWN0) & req0;
  assign gnt1 = ~reset & (state_reg == OWN1) & req1;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_addr  = addr0;
      ram_we    = we0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_addr  = addr1;
      ram_we    = we1;
      ram_wdata = wdata1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= ram_rdata;
      if (gnt1 && !we1) rdata1 <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a grant/burst reference model predicts
// bus traffic and read data; a monitor matches rvalid pulses against it.
module tb_mem_arbiter;

  localparam int MAX_BURST = 4;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [31:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mem [0:255];
  bit          ram_loaded = 1'b0;
  logic [31:0] model_mem [0:255];
  bit          model_loaded = 1'b0;
  int          m_owner = -1;
  int          m_last = 1;
  int          m_streak = 0;
  rd_t         q0[$];
  rd_t         q1[$];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A000000 ^ (32'(a) * 32'h00010203);
  endfunction

  // External RAM: combinational read, write on the clock edge.
  assign ram_rdata = mem[ram_addr[7:0]];
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_wdata;
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many grants this tenure, who won last.
  always @(negedge clock) begin : model
    logic [1:0]  eg;
    logic [95:0] er;
    int          win;
    logic        own_r, oth_r;
    rd_t         e;
    if (!model_loaded) begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
      model_loaded = 1'b1;
    end
    if (reset) begin
      m_owner = -1;
      m_last = 1;
      m_streak = 0;
      q0.delete();
      q1.delete();
      check("reset_ctl", 96'({gnt1, gnt0, rvalid1, rvalid0, ram_we}), 96'(0));
      check("reset_bus", {ram_addr, ram_wdata, rdata0}, 96'(0));
      check("reset_rdata1", 96'(rdata1), 96'(0));
    end else begin
      eg = 2'b00;
      if (m_owner == 0 && req0) eg = 2'b01;
      if (m_owner == 1 && req1) eg = 2'b10;
      er = 96'(0);
      if (eg[0]) er = {31'd0, we0, addr0, wdata0};
      if (eg[1]) er = {31'd0, we1, addr1, wdata1};
      check("gnt", 96'({gnt1, gnt0}), 96'(eg));
      check("ram_bus", {31'd0, ram_we, ram_addr, ram_wdata}, er);
      if (eg != 2'b00) begin
        if (er[64]) begin
          model_mem[er[39:32]] = er[31:0];
        end else begin
          e.data = model_mem[er[39:32]];
          e.cyc  = cyc + 1;
          if (eg[0]) q0.push_back(e);
          else q1.push_back(e);
        end
      end
      win = -1;
      if (m_owner < 0) begin
        if (req0 && req1) win = (m_last == 0) ? 1 : 0;
        else if (req0) win = 0;
        else if (req1) win = 1;
      end else begin
        own_r = (m_owner == 0) ? req0 : req1;
        oth_r = (m_owner == 0) ? req1 : req0;
        if (!own_r) begin
          if (oth_r) win = 1 - m_owner;
          else m_owner = -1;
        end else begin
          m_streak++;
          if (m_streak >= MAX_BURST && oth_r) win = 1 - m_owner;
        end
      end
      if (win >= 0) begin
        m_owner = win;
        m_last = win;
        m_streak = 0;
      end
    end
  end

  // Monitor: every rvalid pulse must match the oldest expected read, on time.
  always @(negedge clock) begin : monitor
    rd_t e;
    if (!reset) begin
      if (rvalid0) begin
        if (q0.size() == 0) check("rvalid0_extra", 96'(rvalid0), 96'(0));
        else begin
          e = q0.pop_front();
          check("rdata0", {32'd0, 32'(cyc), rdata0}, {32'd0, 32'(e.cyc), e.data});
        end
      end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
        check("rvalid0_missing", 96'(rvalid0), 96'(1));
        e = q0.pop_front();
      end
      if (rvalid1) begin
        if (q1.size() == 0) check("rvalid1_extra", 96'(rvalid1), 96'(0));
        else begin
          e = q1.pop_front();
          check("rdata1", {32'd0, 32'(cyc), rdata1}, {32'd0, 32'(e.cyc), e.data});
        end
      end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        check("rvalid1_missing", 96'(rvalid1), 96'(1));
        e = q1.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Raise a request, hold it until granted (bounded), then drop it.
  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    set_port(p, 1'b1, w, a, d);
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clock);
      got = (p == 0) ? gnt0 : gnt1;
      tick();
    end
    check("txn_granted", 96'(got), 96'(1));
    set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rand_port(input int p);
    if ($urandom_range(0, 99) < 65)
      set_port(p, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), 32'($urandom));
    else
      set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt;
    logic g0, g1;
    logic [1:0] exp_g;

    repeat (2) tick();
    reset = 1'b0;

    // Continuous tie from reset: port 0 first, bursts of MAX_BURST, no gaps.
    set_port(0, 1'b1, 1'b0, 32'd1, 32'd0);
    set_port(1, 1'b1, 1'b0, 32'd2, 32'd0);
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      if (k == 0) exp_g = 2'b00;
      else exp_g = (((k - 1) / MAX_BURST) % 2 == 0) ? 2'b01 : 2'b10;
      check("tie_gnt", 96'({gnt1, gnt0}), 96'(exp_g));
      tick();
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();

    // Single read from IDLE: grant one cycle later, data one cycle after that.
    set_port(0, 1'b1, 1'b0, 32'h10, 32'd0);
    @(negedge clock);
    check("single_wait", 96'({gnt1, gnt0}), 96'(2'b00));
    tick();
    @(negedge clock);
    check("single_gnt", 96'({gnt1, gnt0}), 96'(2'b01));
    check("single_addr", 96'(ram_addr), 96'(32'h10));
    tick();
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("single_rvalid", 96'(rvalid0), 96'(1));
    check("single_rdata", 96'(rdata0), 96'(init_word(16)));
    tick();

    // Port 1 writes, port 0 reads the same location back.
    do_txn(1, 1'b1, 32'h20, 32'hDEADBEEF);
    do_txn(0, 1'b0, 32'h20, 32'd0);
    @(negedge clock);
    check("wr_rd_valid", 96'(rvalid0), 96'(1));
    check("wr_rd_data", 96'(rdata0), 96'(32'hDEADBEEF));
    tick();

    // Lone requester keeps the bus; a late competitor takes over next cycle.
    set_port(0, 1'b1, 1'b0, 32'd3, 32'd0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      cnt += int'(gnt0);
      tick();
    end
    check("sat_count", 96'(cnt), 96'(19));
    set_port(1, 1'b1, 1'b0, 32'd4, 32'd0);
    @(negedge clock);
    check("sat_hold", 96'({gnt1, gnt0}), 96'(2'b01));
    tick();
    @(negedge clock);
    check("sat_switch", 96'({gnt1, gnt0}), 96'(2'b10));
    tick();
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) tick();

    // Owner 1 drops its request while port 0 waits.
    set_port(1, 1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clock);
    check("drop_idle", 96'({gnt1, gnt0}), 96'(2'b00));
    tick();
    @(negedge clock);
    check("drop_g1a", 96'({gnt1, gnt0}), 96'(2'b10));
    tick();
    set_port(0, 1'b1, 1'b0, 32'd6, 32'd0);
    @(negedge clock);
    check("drop_g1b", 96'({gnt1, gnt0}), 96'(2'b10));
    tick();
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clock);
    check("drop_gap", 96'({gnt1, gnt0}), 96'(2'b00));
    tick();
    @(negedge clock);
    check("drop_g0", 96'({gnt1, gnt0}), 96'(2'b01));
    tick();
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) tick();

    // Reset during a granted write: bus must go quiet and the RAM keep its value.
    set_port(0, 1'b1, 1'b1, 32'h30, 32'h12345678);
    @(negedge clock);
    check("rst_idle", 96'({gnt1, gnt0}), 96'(2'b00));
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_bus", 96'({gnt1, gnt0, ram_we}), 96'(0));
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    reset = 1'b0;
    check("rst_mem", 96'(mem[8'h30]), 96'(init_word(48)));
    do_txn(0, 1'b0, 32'h30, 32'd0);
    @(negedge clock);
    check("rst_readback_valid", 96'(rvalid0), 96'(1));
    check("rst_readback", 96'(rdata0), 96'(init_word(48)));
    tick();

    // Randomised traffic; requests held until granted, then renewed or dropped.
    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      g0 = gnt0;
      g1 = gnt1;
      tick();
      if (!req0 || g0) rand_port(0);
      if (!req1 || g1) rand_port(1);
    end
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) tick();
    check("rd_drain", 96'(q0.size() + q1.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
